// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - serial double-dabble binary to packed-BCD converter
module bin2bcd_serial #(
    parameter int          BIN_WIDTH = 20,
    parameter int          DIGITS    = 6,
    parameter int unsigned MAX_VAL   = 999999
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [BIN_WIDTH-1:0]  i_bin,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    // Packed-BCD image of MAX_VAL, used as the saturated result.
    function automatic logic [BCD_W-1:0] to_bcd(input longint unsigned v);
        logic [BCD_W-1:0] r;
        longint unsigned  t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(longint'(MAX_VAL));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [BIN_WIDTH-1:0]  r_sh;
    logic [BCD_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ovf;
    logic [BCD_W-1:0]      r_bcd;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_overflow;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_in_ovf;
    logic [BCD_W-1:0]      w_adj;
    logic [BCD_W-1:0]      w_acc_next;

    assign w_in_ovf = 64'(i_bin) > 64'(MAX_VAL);

    // Add-3 correction on every nibble of the pre-shift accumulator, then
    // shift with the binary MSB entering at the bottom; the top bit drops.
    always_comb begin
        w_adj = r_acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_acc[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
            end
        end
        w_acc_next = (w_adj << 1) | {{(BCD_W-1){1'b0}}, r_sh[BIN_WIDTH-1]};
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(BIN_WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Working registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_bcd      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_sh   <= i_bin;
                r_acc  <= '0;
                r_cnt  <= '0;
                r_ovf  <= w_in_ovf;
                r_busy <= 1'b1;
            end else if (r_state == S_SHIFT) begin
                r_sh  <= r_sh << 1;
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_bcd      <= r_ovf ? MAX_BCD : w_acc_next;
                    r_overflow <= r_ovf;
                    r_valid    <= 1'b1;
                end
            end else if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_bcd      = r_bcd;
    assign o_valid    = r_valid;
    assign o_busy     = r_busy;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// tb/tb_bin2bcd_serial.sv - directed and swept checks for bin2bcd_serial
module tb_bin2bcd_serial;

    logic        clk;
    logic        reset;
    logic        start;
    logic [19:0] bin;
    logic [23:0] bcd;
    logic        valid;
    logic        busy;
    logic        overflow;

    int n_checks;
    int n_fail;

    bin2bcd_serial dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_bin      (bin),
        .o_bcd      (bcd),
        .o_valid    (valid),
        .o_busy     (busy),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0]  r;
        int unsigned  t;
        if (v > 999999) return 24'h999999;
        r = '0;
        t = v;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Accept one value, then check latency, busy length, result and teardown.
    task automatic run_conv(input string tag, input logic [19:0] v,
                            input logic [23:0] exp_bcd, input logic exp_ovf);
        int lat;
        int busy_cnt;
        bin   = v;
        start = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!valid && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        if (busy) busy_cnt++;
        check({tag, " latency"}, lat, 20);
        check({tag, " bcd"}, {8'h0, bcd}, {8'h0, exp_bcd});
        check({tag, " ovf"}, {31'h0, overflow}, {31'h0, exp_ovf});
        tick();
        check({tag, " busy cycles"}, busy_cnt, 21);
        check({tag, " valid drop"}, {31'h0, valid}, 32'h0);
        check({tag, " busy drop"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int vcount;
        int t_valid[3];
        int idx;
        int cyc;
        logic [23:0] got[3];
        logic [19:0] seq[3];

        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset bcd", {8'h0, bcd}, 32'h0);
        check("reset valid", {31'h0, valid}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset ovf", {31'h0, overflow}, 32'h0);

        run_conv("zero", 20'd0, 24'h000000, 1'b0);
        run_conv("123456", 20'd123456, 24'h123456, 1'b0);
        run_conv("999999", 20'd999999, 24'h999999, 1'b0);
        run_conv("9", 20'd9, 24'h000009, 1'b0);
        run_conv("1000000", 20'd1000000, 24'h999999, 1'b1);
        run_conv("42", 20'd42, 24'h000042, 1'b0);
        run_conv("1048575", 20'd1048575, 24'h999999, 1'b1);

        // Start while busy is dropped; input change after accept is ignored.
        bin   = 20'd500;
        start = 1'b1;
        tick();
        start = 1'b0;
        bin   = 20'd3;
        repeat (4) tick();
        bin   = 20'd777;
        start = 1'b1;
        tick();
        start  = 1'b0;
        vcount = 0;
        for (int i = 0; i < 50; i++) begin
            if (valid) begin
                vcount++;
                check("busy-start bcd", {8'h0, bcd}, 32'h000500);
            end
            tick();
        end
        check("busy-start pulses", vcount, 1);

        // Reset mid-conversion aborts and clears.
        bin   = 20'd654321;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort bcd", {8'h0, bcd}, 32'h0);
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort valid", {31'h0, valid}, 32'h0);
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            if (valid) vcount++;
            tick();
        end
        check("abort no valid", vcount, 0);
        run_conv("after abort", 20'd31, 24'h000031, 1'b0);

        // Continuous start: one conversion every 22 cycles.
        seq[0] = 20'd1;
        seq[1] = 20'd22;
        seq[2] = 20'd333;
        bin   = seq[0];
        start = 1'b1;
        tick();
        idx = 0;
        cyc = 0;
        while (idx < 3 && cyc < 100) begin
            tick();
            cyc++;
            if (valid) begin
                t_valid[idx] = cyc;
                got[idx]     = bcd;
                idx++;
                if (idx < 3) bin = seq[idx];
                else start = 1'b0;
            end
        end
        start = 1'b0;
        check("stream count", idx, 3);
        if (idx == 3) begin
            check("stream bcd0", {8'h0, got[0]}, 32'h000001);
            check("stream bcd1", {8'h0, got[1]}, 32'h000022);
            check("stream bcd2", {8'h0, got[2]}, 32'h000333);
            check("stream gap01", t_valid[1] - t_valid[0], 22);
            check("stream gap12", t_valid[2] - t_valid[1], 22);
        end
        repeat (3) tick();

        // Sweep including the saturation boundary.
        run_conv("edge 999998", 20'd999998, ref_bcd(999998), 1'b0);
        run_conv("edge 1000001", 20'd1000001, ref_bcd(1000001), 1'b1);
        for (int i = 0; i < 24; i++) begin
            int unsigned v;
            v = $urandom_range(0, 1048575);
            run_conv("sweep", 20'(v), ref_bcd(v), v > 999999);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
